// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the CPU-side memory access unit.
package mem_access_unit_pkg;

    // Transaction sequencer states; encodings are shared with the RAM side.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } mau_state_e;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

endpackage : mem_access_unit_pkg

// File: rtl/mem_access_unit.sv
// MAR/MDR holder that sequences one-shot read and write transactions to a
// synchronous RAM and reports completion (done) or rejected requests (req_err).
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] mdr_q,
    output logic [ADDR_W-1:0] mar_q,
    output logic              busy,
    output logic              done,
    output logic              req_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int LCNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(READ_LATENCY - 1);

    mau_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] mar_d;
    logic [DATA_W-1:0] mdr_d;
    logic [LCNT_W-1:0] lat_cnt_q,   lat_cnt_d;
    logic              ram_read_q,  ram_read_d;
    logic              ram_write_q, ram_write_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              req_err_q,   req_err_d;
    logic              any_req_s;

    // Any control input asserted; used to flag requests arriving while busy.
    assign any_req_s = mar_in | mdr_in | mem_read | mem_write;

    // Next-state logic: FSM, MAR/MDR loads and read-latency countdown.
    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        mdr_d       = mdr_q;
        lat_cnt_d   = lat_cnt_q;
        ram_read_d  = ram_read_q;
        ram_write_d = ram_write_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        req_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Loads take effect on the same edge a request is accepted,
                // so the RAM sees the freshly loaded MAR/MDR on the strobe.
                if (mar_in) begin
                    mar_d = bus_in[ADDR_W-1:0];
                end else begin
                    mar_d = mar_q;
                end
                if (mdr_in) begin
                    mdr_d = bus_in;
                end else begin
                    mdr_d = mdr_q;
                end
                if (mem_read && mem_write) begin
                    req_err_d = 1'b1;
                end else if (mem_read) begin
                    state_d    = ST_RD;
                    ram_read_d = 1'b1;
                    busy_d     = 1'b1;
                    lat_cnt_d  = LCNT_INIT;
                end else if (mem_write) begin
                    state_d     = ST_WR;
                    ram_write_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                req_err_d = any_req_s;
                if (ram_read_q) begin
                    // Strobe phase: hold ram_read for READ_LATENCY cycles.
                    if (lat_cnt_q != LCNT_W'(0)) begin
                        lat_cnt_d = lat_cnt_q - LCNT_W'(1);
                    end else begin
                        ram_read_d = 1'b0;
                    end
                end else begin
                    // Capture phase: RAM output is registered and valid now.
                    mdr_d   = ram_rdata;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                req_err_d   = any_req_s;
                ram_write_d = 1'b0;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                ram_read_d  = 1'b0;
                ram_write_d = 1'b0;
                busy_d      = 1'b0;
                lat_cnt_d   = LCNT_W'(0);
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            mar_q       <= {ADDR_W{1'b0}};
            mdr_q       <= {DATA_W{1'b0}};
            lat_cnt_q   <= {LCNT_W{1'b0}};
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            lat_cnt_q   <= lat_cnt_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_err_q   <= req_err_d;
        end
    end

    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_err   = req_err_q;
    assign ram_addr  = mar_q;
    assign ram_wdata = mdr_q;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: two builds (READ_LATENCY 1 and 3), each with a
// behavioural 512x32 synchronous RAM. Completions and error pulses of the
// LAT=1 build are checked by a scoreboard monitor.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        clear_n;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // ---------------- LAT=1 build ----------------
    logic [31:0] bus_in;
    logic        mar_in, mdr_in, mem_read, mem_write;
    logic [31:0] mdr_q, ram_wdata, ram_rdata;
    logic [8:0]  mar_q, ram_addr;
    logic        busy, done, req_err, ram_read, ram_write;
    logic [31:0] mem1 [0:511];

    mem_access_unit #(.ADDR_W(9), .DATA_W(32), .READ_LATENCY(1)) dut (
        .clk(clk), .clear_n(clear_n), .bus_in(bus_in), .mar_in(mar_in),
        .mdr_in(mdr_in), .mem_read(mem_read), .mem_write(mem_write),
        .mdr_q(mdr_q), .mar_q(mar_q), .busy(busy), .done(done),
        .req_err(req_err), .ram_addr(ram_addr), .ram_read(ram_read),
        .ram_write(ram_write), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // ---------------- LAT=3 build ----------------
    logic [31:0] bus3;
    logic        mar_in3, mdr_in3, rd3, wr3;
    logic [31:0] mdr3, wdata3, rdata3;
    logic [8:0]  mar3, addr3;
    logic        busy3, done3, err3, ram_rd3, ram_wr3;
    logic [31:0] mem3 [0:511];

    mem_access_unit #(.ADDR_W(9), .DATA_W(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .clear_n(clear_n), .bus_in(bus3), .mar_in(mar_in3),
        .mdr_in(mdr_in3), .mem_read(rd3), .mem_write(wr3),
        .mdr_q(mdr3), .mar_q(mar3), .busy(busy3), .done(done3),
        .req_err(err3), .ram_addr(addr3), .ram_read(ram_rd3),
        .ram_write(ram_wr3), .ram_wdata(wdata3), .ram_rdata(rdata3)
    );

    always #5 clk = ~clk;

    // Cycle counter: value k after the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous RAMs: write and registered read on posedge.
    always @(posedge clk) begin
        if (ram_write) mem1[ram_addr] <= ram_wdata;
        if (ram_read)  ram_rdata      <= mem1[ram_addr];
        if (ram_wr3)   mem3[addr3]    <= wdata3;
        if (ram_rd3)   rdata3         <= mem3[addr3];
    end

    typedef struct {
        int          cyc;
        logic [31:0] mdr;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the LAT=1 build presents done/req_err.
    always @(negedge clk) begin
        if (clear_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no pending transaction (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_mdr", mdr_q, e.mdr);
                end
            end
            if (req_err) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req_err: req_err=1 not expected (cycle %0d)", cyc);
                end else begin
                    int ec;
                    ec = err_q.pop_front();
                    chk("req_err_cycle", cyc, ec);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Apply one cycle of control inputs to the LAT=1 build, then return to idle.
    task automatic op(input logic mi, input logic di, input logic rd, input logic wr,
                      input logic [31:0] b);
        bus_in = b; mar_in = mi; mdr_in = di; mem_read = rd; mem_write = wr;
        @(negedge clk);
        mar_in = 1'b0; mdr_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // Watchdog: the run must always end.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c;
        for (int i = 0; i < 512; i++) begin
            mem1[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem1[9'h055] = 32'h1234_ABCD;
        mem3[9'h020] = 32'hCAFE_F00D;
        clear_n = 1'b0;
        bus_in = 32'h0; mar_in = 1'b0; mdr_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        bus3 = 32'h0; mar_in3 = 1'b0; mdr_in3 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        tick(); tick();
        // Reset state
        chk("rst_mdr", mdr_q, 32'h0);
        chk("rst_mar", {23'h0, mar_q}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_req_err", {31'h0, req_err}, 32'h0);
        chk("rst_strobes", {30'h0, ram_read, ram_write}, 32'h0);
        clear_n = 1'b1;
        tick();

        // 1. Reset mid-read aborts: outputs clear at once, no done pulse.
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
        chk("t1_mdr_load", mdr_q, 32'h0BAD_F00D);
        op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        tick();
        #2 clear_n = 1'b0;
        #1;
        chk("t1_async_busy", {31'h0, busy}, 32'h0);
        chk("t1_async_mdr", mdr_q, 32'h0);
        chk("t1_async_outs", {27'h0, done, req_err, ram_read, ram_write, 1'b0}, 32'h0);
        tick(); tick();
        clear_n = 1'b1;
        tick();

        // 2. Load MAR=0x55 then read RAM[0x55].
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0055);
        chk("t2_mar", {23'h0, mar_q}, 32'h55);
        c = cyc;
        exp_q.push_back('{c + 3, 32'h1234_ABCD});
        op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t2_rd_e0", {31'h0, ram_read}, 32'h1);
        tick();
        chk("t2_rd_e1", {31'h0, ram_read}, 32'h0);
        tick(); tick();
        chk("t2_idle_busy", {31'h0, busy}, 32'h0);

        // 3. Write 0xDEADBEEF to 0x1FF, then read it back.
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_01FF);
        c = cyc;
        exp_q.push_back('{c + 2, 32'hDEAD_BEEF});
        op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("t3_wr_e0", {31'h0, ram_write}, 32'h1);
        tick();
        chk("t3_wr_e1", {31'h0, ram_write}, 32'h0);
        chk("t3_ram_1ff", mem1[9'h1FF], 32'hDEAD_BEEF);
        tick();
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        c = cyc;
        exp_q.push_back('{c + 3, 32'hDEAD_BEEF});
        op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick(); tick(); tick();

        // 4. Simultaneous read and write in IDLE is rejected.
        c = cyc;
        err_q.push_back(c + 1);
        op(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("t4_busy", {31'h0, busy}, 32'h0);
        chk("t4_strobes", {30'h0, ram_read, ram_write}, 32'h0);
        tick();
        chk("t4_busy_after", {31'h0, busy}, 32'h0);

        // 5. MAR load while busy is ignored; a request in the done cycle is accepted.
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0055);
        c = cyc;
        exp_q.push_back('{c + 3, 32'h1234_ABCD});
        op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        err_q.push_back(c + 2);
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010);
        chk("t5_mar_frozen", {23'h0, mar_q}, 32'h55);
        tick();
        chk("t5_done_cycle_now", {31'h0, done}, 32'h1);
        exp_q.push_back('{c + 5, 32'hA5A5_0001});
        op(1'b0, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001);
        chk("t5_b2b_write", {31'h0, ram_write}, 32'h1);
        tick();
        chk("t5_ram_55", mem1[9'h055], 32'hA5A5_0001);
        tick(); tick();

        // 6. READ_LATENCY=3 build: load MAR and read on the same edge.
        bus3 = 32'h0000_0020; mar_in3 = 1'b1; rd3 = 1'b1;
        tick();
        mar_in3 = 1'b0; rd3 = 1'b0;
        chk("t6_addr", {23'h0, addr3}, 32'h20);
        chk("t6_rd_e0", {31'h0, ram_rd3}, 32'h1);
        tick();
        chk("t6_rd_e1", {31'h0, ram_rd3}, 32'h1);
        tick();
        chk("t6_rd_e2", {31'h0, ram_rd3}, 32'h1);
        tick();
        chk("t6_rd_e3", {31'h0, ram_rd3}, 32'h0);
        chk("t6_done_e3", {31'h0, done3}, 32'h0);
        tick();
        chk("t6_done_e4", {31'h0, done3}, 32'h1);
        chk("t6_mdr", mdr3, 32'hCAFE_F00D);
        chk("t6_busy_e4", {31'h0, busy3}, 32'h0);
        tick();
        chk("t6_done_e5", {31'h0, done3}, 32'h0);
        chk("t6_err", {31'h0, err3}, 32'h0);

        tick(); tick();
        chk("pending_done", exp_q.size(), 32'h0);
        chk("pending_req_err", err_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_access_unit
